lcd_frame_writer: RTL

Consumer end of the column-byte stream produced by the frame-buffer RAM controller: requests one 8-bit LCD column byte at a time over the `en`/`data_valid` handshake and writes it to a KS0108-style 128×64 dual-controller graphic LCD. It initialises the panel, clears the right half once, then continuously refreshes the 64×64 image on the left half (8 pages × 64 columns). It sits between the RAM controller and the board LCD pins.

---
 rtl/lcd_pkg.sv | 23 ++
 rtl/lcd_bus_cycle.sv | 78 +++++++
 rtl/lcd_frame_writer.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the KS0108 frame writer.
package lcd_pkg;

  localparam logic [7:0] CMD_DISPLAY_ON = 8'h3F;
  localparam logic [7:0] CMD_START_LINE = 8'hC0;
  localparam logic [7:0] CMD_PAGE_BASE  = 8'hB8;
  localparam logic [7:0] CMD_COL_BASE   = 8'h40;

  localparam logic [1:0] CS_LEFT  = 2'b01;
  localparam logic [1:0] CS_RIGHT = 2'b10;
  localparam logic [1:0] CS_BOTH  = 2'b11;

  typedef enum logic [3:0] {
    RST_HOLD, INIT_ON, INIT_START, CLR_PAGE, CLR_COL, CLR_DATA, PAGE, COL, REQ, XFER
  } state_t;

  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_HIGH, PH_LOW} phase_t;

  function automatic logic [7:0] page_cmd(input logic [2:0] p);
    return CMD_PAGE_BASE | {5'b00000, p};
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One KS0108 bus cycle: setup, E_HIGH cycles of enable high, E_LOW cycles low.
module lcd_bus_cycle
  import lcd_pkg::*;
#(
  parameter int E_HIGH = 4,
  parameter int E_LOW  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       di,
  input  logic [1:0] cs,
  input  logic [7:0] bus_byte,
  output logic [1:0] lcd_cs,
  output logic       lcd_di,
  output logic [7:0] lcd_data,
  output logic       lcd_en,
  output logic       done
);

  localparam logic [7:0] HI_LAST = 8'(E_HIGH - 1);
  localparam logic [7:0] LO_LAST = 8'(E_LOW - 1);

  phase_t     phase_q, phase_d;
  logic [7:0] cnt_q, cnt_d;

  // Pin values are loaded on start and held until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH_IDLE;
      cnt_q    <= '0;
      lcd_cs   <= 2'b00;
      lcd_di   <= 1'b0;
      lcd_data <= 8'h00;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      if (start) begin
        lcd_cs   <= cs;
        lcd_di   <= di;
        lcd_data <= bus_byte;
      end
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (start) begin
      phase_d = PH_SETUP;
      cnt_d   = '0;
    end else begin
      case (phase_q)
        PH_SETUP: begin
          phase_d = PH_HIGH;
          cnt_d   = '0;
        end
        PH_HIGH: begin
          if (cnt_q == HI_LAST) begin
            phase_d = PH_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        PH_LOW: begin
          if (cnt_q == LO_LAST) phase_d = PH_IDLE;
          else                  cnt_d   = cnt_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign lcd_en = (phase_q == PH_HIGH);
  assign done   = (phase_q == PH_LOW) && (cnt_q == LO_LAST);

endmodule

// File: rtl/lcd_frame_writer.sv
// Initialises a KS0108 128x64 panel, clears the right half once, then streams
// the 64x64 left-half image forever from the RAM controller's byte handshake.
module lcd_frame_writer
  import lcd_pkg::*;
#(
  parameter int E_HIGH  = 4,
  parameter int E_LOW   = 4,
  parameter int RST_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       data_valid,
  output logic       en,
  output logic       LCD_rst,
  output logic [1:0] LCD_cs,
  output logic       LCD_rw,
  output logic       LCD_di,
  output logic [7:0] LCD_data,
  output logic       LCD_en,
  output logic       frame_done,
  output state_t     dbg_state
);

  localparam logic [7:0] RST_LAST = 8'(RST_CYC - 1);

  state_t     state_q, state_d;
  logic [2:0] page_q, page_d;
  logic [5:0] col_q, col_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic       fd_d;
  logic       start, bus_di, done;
  logic [1:0] bus_cs;
  logic [7:0] bus_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_HOLD;
      page_q     <= '0;
      col_q      <= '0;
      rst_cnt_q  <= '0;
      LCD_rst    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      page_q     <= page_d;
      col_q      <= col_d;
      rst_cnt_q  <= rst_cnt_d;
      frame_done <= fd_d;
      if (state_q == RST_HOLD && rst_cnt_q == RST_LAST) LCD_rst <= 1'b1;
    end
  end

  // Each bus cycle is launched on the transition into the state that owns it,
  // so the next cycle's setup phase begins right after the previous done.
  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    col_d     = col_q;
    rst_cnt_d = rst_cnt_q;
    fd_d      = 1'b0;
    start     = 1'b0;
    bus_cs    = CS_LEFT;
    bus_di    = 1'b0;
    bus_byte  = 8'h00;
    case (state_q)
      RST_HOLD: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d  = INIT_ON;
          start    = 1'b1;
          bus_cs   = CS_BOTH;
          bus_byte = CMD_DISPLAY_ON;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      INIT_ON: if (done) begin
        state_d  = INIT_START;
        start    = 1'b1;
        bus_cs   = CS_BOTH;
        bus_byte = CMD_START_LINE;
      end
      INIT_START: if (done) begin
        state_d  = CLR_PAGE;
        page_d   = 3'd0;
        start    = 1'b1;
        bus_cs   = CS_RIGHT;
        bus_byte = page_cmd(3'd0);
      end
      CLR_PAGE: if (done) begin
        state_d  = CLR_COL;
        col_d    = 6'd0;
        start    = 1'b1;
        bus_cs   = CS_RIGHT;
        bus_byte = CMD_COL_BASE;
      end
      CLR_COL: if (done) begin
        state_d = CLR_DATA;
        start   = 1'b1;
        bus_cs  = CS_RIGHT;
        bus_di  = 1'b1;
      end
      CLR_DATA: if (done) begin
        col_d = col_q + 6'd1;
        start = 1'b1;
        if (col_q == 6'd63) begin
          page_d   = page_q + 3'd1;
          bus_byte = page_cmd(page_q + 3'd1);
          if (page_q == 3'd7) begin
            state_d = PAGE;
            bus_cs  = CS_LEFT;
          end else begin
            state_d = CLR_PAGE;
            bus_cs  = CS_RIGHT;
          end
        end else begin
          bus_cs = CS_RIGHT;
          bus_di = 1'b1;
        end
      end
      PAGE: if (done) begin
        state_d  = COL;
        col_d    = 6'd0;
        start    = 1'b1;
        bus_byte = CMD_COL_BASE;
      end
      COL: if (done) state_d = REQ;
      REQ: if (data_valid) begin
        state_d  = XFER;
        start    = 1'b1;
        bus_di   = 1'b1;
        bus_byte = data;
      end
      XFER: if (done) begin
        col_d = col_q + 6'd1;
        if (col_q == 6'd63) begin
          state_d  = PAGE;
          page_d   = page_q + 3'd1;
          start    = 1'b1;
          bus_byte = page_cmd(page_q + 3'd1);
          fd_d     = (page_q == 3'd7);
        end else begin
          state_d = REQ;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  // Valid/ready: en requests one byte; the responder answers with a one-cycle
  // data_valid later and en drops in that same cycle so only one is consumed.
  assign en        = (state_q == REQ) & ~data_valid;
  assign LCD_rw    = 1'b0;
  assign dbg_state = state_q;

  lcd_bus_cycle #(.E_HIGH(E_HIGH), .E_LOW(E_LOW)) u_bus (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .di       (bus_di),
    .cs       (bus_cs),
    .bus_byte (bus_byte),
    .lcd_cs   (LCD_cs),
    .lcd_di   (LCD_di),
    .lcd_data (LCD_data),
    .lcd_en   (LCD_en),
    .done     (done)
  );

endmodule
